display_controller: RTL and testbench

DISPLAY_CONTROLLER -- requirements
Module: display_controller

---
 rtl/display_controller.sv | 113 +++++++++++
 tb/tb_display_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/display_controller.sv
// -----------------------------------------------------------------------------
// display_controller
//
// Time-multiplexed driver for an eight-digit hex display. A refresh divider
// selects one digit slot at a time. The digit index, its nibble and the anode
// pattern are produced from registered state. New data is held in a pending
// register and moved into the display register only at a frame boundary, so
// a single frame never shows a mix of old and new data.
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (2 .. 2**20)
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   data[31:0]   eight nibbles; nibble k drives digit k
//   load         one-cycle strobe capturing data
//   digit_en[7:0] per-digit enable (0 = dark)
//   lz_suppress  blank leading-zero digits
//   hex[3:0]     nibble of the current digit
//   blank        current digit is dark
//   AN[7:0]      active-low anode drive, at most one bit low
//   digit_sel[2:0] current digit index
//   frame_tick   one-cycle pulse after each frame wrap
// -----------------------------------------------------------------------------
module display_controller #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data,
  input  logic        load,
  input  logic [7:0]  digit_en,
  input  logic        lz_suppress,
  output logic [3:0]  hex,
  output logic        blank,
  output logic [7:0]  AN,
  output logic [2:0]  digit_sel,
  output logic        frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt_reg;
  logic [2:0]    idx_reg;
  logic [31:0]   disp_reg;
  logic [31:0]   pend_reg;
  logic          pend_valid_reg;
  logic          frame_tick_reg;

  logic          slot_tick;
  logic          frame_edge;
  logic [7:0]    upper_zero;
  logic          lz_blank;

  assign slot_tick  = (cnt_reg == CNT_LAST);
  assign frame_edge = slot_tick && (idx_reg == 3'd7);

  // Refresh divider and digit index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (slot_tick) begin
      cnt_reg <= '0;
      idx_reg <= idx_reg + 3'd1;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  // Double-buffered data path. A load landing on the boundary cycle itself
  // goes straight to the display and makes any older pending value stale.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_reg       <= '0;
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      frame_tick_reg <= frame_edge;
      if (frame_edge) begin
        if (load) begin
          disp_reg <= data;
        end else if (pend_valid_reg) begin
          disp_reg <= pend_reg;
        end
        pend_valid_reg <= 1'b0;
      end else if (load) begin
        pend_reg       <= data;
        pend_valid_reg <= 1'b1;
      end
    end
  end

  // upper_zero[k]: display nibbles k..7 are all zero.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (disp_reg[31:4*gi] == '0);
    end
  endgenerate

  // Digit 0 is always shown so a zero value still displays "0".
  assign lz_blank = lz_suppress && (idx_reg != 3'd0) && upper_zero[idx_reg];

  assign hex        = disp_reg[{idx_reg, 2'b00} +: 4];
  assign digit_sel  = idx_reg;
  assign blank      = ~digit_en[idx_reg] | lz_blank;
  assign AN         = blank ? 8'hFF : ~(8'h01 << idx_reg);
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_display_controller.sv
// -----------------------------------------------------------------------------
// tb_display_controller
//
// Directed and randomized stimulus against a behavioural model. The model
// counts clock edges since reset release and derives the digit index and
// frame boundaries arithmetically; it keeps display / pending contents as
// plain variables updated by the load rules.
// -----------------------------------------------------------------------------
module tb_display_controller;

  localparam int DIV = 4;
  localparam int FRAME = 8 * DIV;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data = '0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic        lz_suppress = 1'b0;
  logic [3:0]  hex;
  logic        blank;
  logic [7:0]  AN;
  logic [2:0]  digit_sel;
  logic        frame_tick;

  display_controller #(.REFRESH_DIV(DIV)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data        (data),
    .load        (load),
    .digit_en    (digit_en),
    .lz_suppress (lz_suppress),
    .hex         (hex),
    .blank       (blank),
    .AN          (AN),
    .digit_sel   (digit_sel),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  int          cyc = 0;
  logic [31:0] m_disp = '0;
  logic [31:0] m_pend = '0;
  bit          m_pv = 1'b0;
  bit          m_ft = 1'b0;
  int          ft_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int          k;
    logic [31:0] upper;
    bit          lz;
    bit          bl;
    logic [7:0]  an_e;
    k     = (cyc / DIV) % 8;
    upper = m_disp >> (4 * k);
    lz    = lz_suppress && (k != 0) && (upper == 0);
    bl    = !digit_en[k] || lz;
    an_e  = bl ? 8'hFF : ~(8'h01 << k);
    check({tag, ".digit_sel"}, 32'(digit_sel), 32'(k));
    check({tag, ".hex"}, 32'(hex), 32'(upper[3:0]));
    check({tag, ".blank"}, 32'(blank), 32'(bl));
    check({tag, ".AN"}, 32'(AN), 32'(an_e));
    check({tag, ".frame_tick"}, 32'(frame_tick), 32'(m_ft));
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then check outputs shortly after the opposite edge.
  task automatic step(input string tag);
    bit fb;
    @(posedge clk);
    fb = (cyc % DIV == DIV - 1) && ((cyc / DIV) % 8 == 7);
    if (fb) begin
      if (load) m_disp = data;
      else if (m_pv) m_disp = m_pend;
      m_pv = 1'b0;
    end else if (load) begin
      m_pend = data;
      m_pv   = 1'b1;
    end
    m_ft = fb;
    cyc++;
    @(negedge clk);
    #1;
    if (frame_tick) ft_seen++;
    check_outputs(tag);
  endtask

  task automatic pulse_load(input logic [31:0] d, input string tag);
    data = d;
    load = 1'b1;
    step(tag);
    load = 1'b0;
  endtask

  // Advance until the next edge is a frame boundary (bounded).
  task automatic run_to_pre_boundary(input string tag);
    for (int i = 0; i < FRAME + 1 && (cyc % FRAME) != FRAME - 1; i++) step(tag);
  endtask

  task automatic model_reset();
    cyc    = 0;
    m_disp = '0;
    m_pend = '0;
    m_pv   = 1'b0;
    m_ft   = 1'b0;
  endtask

  initial begin
    // Power-up reset, with a load pulse that must be discarded.
    data = 32'hDEADBEEF;
    load = 1'b1;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset");
    digit_en = 8'h7E;
    #1;
    check_outputs("reset_en0_off");
    digit_en = 8'hFF;
    load = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Scan 40 cycles after release.
    ft_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step("scan");
      if (i == DIV - 2) check("scan.first_slot_AN", 32'(AN), 32'hFE);
      if (i == DIV - 1) check("scan.second_slot_AN", 32'(AN), 32'hFD);
    end
    check("scan.frame_tick_count", 32'(ft_seen), 32'd1);

    // Atomic update: load mid-frame, display only changes at the boundary.
    pulse_load(32'h12345678, "atomic_load");
    run_to_pre_boundary("atomic_wait");
    check("atomic.hex_before", 32'(hex), 32'h0);
    step("atomic_boundary");
    for (int k = 0; k < 8; k++) begin
      check("atomic.hex_seq", 32'(hex), 32'(8 - k));
      repeat (DIV) step("atomic_frame");
    end

    // Simultaneous load on the boundary cycle overrides the pending value.
    repeat (5) step("simul_pre");
    pulse_load(32'hAAAAAAAA, "simul_pending");
    run_to_pre_boundary("simul_wait");
    pulse_load(32'h55555555, "simul_boundary");
    check("simul.hex_new", 32'(hex), 32'h5);
    repeat (FRAME) step("simul_frame1");
    check("simul.hex_kept", 32'(hex), 32'h5);
    repeat (FRAME) step("simul_frame2");

    // Leading-zero suppression.
    lz_suppress = 1'b1;
    pulse_load(32'h000000A0, "lz_load");
    run_to_pre_boundary("lz_wait");
    repeat (FRAME + 1) step("lz_frame_a0");
    pulse_load(32'h00000000, "lz_load0");
    run_to_pre_boundary("lz_wait0");
    repeat (FRAME + 1) step("lz_frame_0");

    // Randomized operation, including same-cycle enable changes.
    for (int i = 0; i < 600; i++) begin
      load = ($urandom % 8 == 0);
      data = $urandom >> ($urandom % 32);
      if ($urandom % 16 == 0) run_to_pre_boundary("rand_align");
      step("rand");
      load = 1'b0;
      digit_en    = 8'($urandom);
      lz_suppress = 1'($urandom % 2);
      #1;
      check_outputs("rand_comb");
    end

    // Mid-operation reset at digit 5 with a pending value outstanding.
    digit_en    = 8'hFF;
    lz_suppress = 1'b0;
    run_to_pre_boundary("midrst_align");
    step("midrst_boundary");
    repeat (4 * DIV) step("midrst_digits");
    pulse_load(32'h87654321, "midrst_load");
    for (int i = 0; i < FRAME && (cyc / DIV) % 8 != 5; i++) step("midrst_to5");
    check("midrst.at_digit5", 32'(digit_sel), 32'd5);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("midrst_reset");
    digit_en = 8'h00;
    #1;
    check_outputs("midrst_reset_off");
    digit_en = 8'hFF;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (FRAME + 8) step("midrst_after");
    check("midrst.hex_zero", 32'(hex), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
